// File: rtl/mont_pkg.sv
// Shared definitions for the bit-serial Montgomery multiplier: default width
// and the controller state encoding.
package mont_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: S += a_i*B, add N if S is odd, halve S.
// Purely combinational; the caller owns all state.
module mont_step
    import mont_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic [DATA_WIDTH+1:0] s_i,
    input  logic                  a_bit_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] n_i,
    output logic [DATA_WIDTH+1:0] s_o
);

    logic [DATA_WIDTH+1:0] sum_b;
    logic [DATA_WIDTH+1:0] sum_n;

    // S < 2N on entry, so S + B + N < 4N and two guard bits are enough.
    always_comb begin
        sum_b = s_i + (a_bit_i ? {2'b00, b_i} : '0);
        sum_n = sum_b[0] ? (sum_b + {2'b00, n_i}) : sum_b;
        s_o   = sum_n >> 1;
    end

endmodule

// File: rtl/montgomery_multiplier.sv
// Bit-serial Montgomery multiplier: result = a*b*R^-1 mod N, one bit of a per
// cycle, iteration count taken from the power-of-two R supplied upstream.
module montgomery_multiplier
    import mont_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [DATA_WIDTH-1:0] modulant,
    input  logic [DATA_WIDTH:0]   r_in,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output state_t                state_dbg
);

    localparam int SW = DATA_WIDTH + 2;
    localparam logic [DATA_WIDTH:0] R_ONE = (DATA_WIDTH+1)'(1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] n_q, n_d;
    logic [DATA_WIDTH:0]   r_q, r_d;
    logic [SW-1:0]         s_q, s_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  bad_q, bad_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  inputs_bad;
    logic [DATA_WIDTH:0]   r_shift;
    logic [SW-1:0]         s_step;
    logic [SW-1:0]         s_sub;

    // Legality is judged on the raw inputs at acceptance; the flag then
    // diverts the first ITER cycle straight to DONE.
    always_comb begin
        inputs_bad = (modulant[0] == 1'b0)
                  || (modulant == '0)
                  || (r_in <= R_ONE)
                  || ((r_in & (r_in - R_ONE)) != '0)
                  || (r_in <= {1'b0, modulant});
        r_shift    = r_q >> 1;
        s_sub      = s_q - {2'b00, n_q};
    end

    mont_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_step (
        .s_i     (s_q),
        .a_bit_i (a_q[0]),
        .b_i     (b_q),
        .n_i     (n_q),
        .s_o     (s_step)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        r_d      = r_q;
        s_d      = s_q;
        result_d = result_q;
        bad_d    = bad_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    n_d     = modulant;
                    r_d     = r_in;
                    s_d     = '0;
                    bad_d   = inputs_bad;
                    state_d = ITER;
                end
            end
            ITER: begin
                if (bad_q) begin
                    result_d = '0;
                    state_d  = DONE;
                end else begin
                    s_d = s_step;
                    a_d = a_q >> 1;
                    r_d = r_shift;
                    if (r_shift == R_ONE) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                result_d = (s_q >= {2'b00, n_q}) ? s_sub[DATA_WIDTH-1:0]
                                                 : s_q[DATA_WIDTH-1:0];
                state_d  = DONE;
            end
            DONE: begin
                done_d  = 1'b1;
                err_d   = bad_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            s_q      <= '0;
            result_q <= '0;
            bad_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            r_q      <= r_d;
            s_q      <= s_d;
            result_q <= result_d;
            bad_q    <= bad_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign result    = result_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_montgomery_multiplier.sv
// Self-checking bench for montgomery_multiplier: directed corner cases plus
// randomized legal operands checked against a modular-arithmetic reference.
module tb_montgomery_multiplier;
    import mont_pkg::*;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] modulant;
    logic [W:0]   r_in;
    logic [W-1:0] result;
    logic         busy;
    logic         done;
    logic         err;
    state_t       state_dbg;

    int total = 0;
    int bad   = 0;

    montgomery_multiplier #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .modulant  (modulant),
        .r_in      (r_in),
        .result    (result),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: smallest power of two above N.
    function automatic int ref_r(input int n);
        int r;
        r = 1;
        while (r <= n) r = r << 1;
        return r;
    endfunction

    function automatic int ref_k(input int r);
        int k;
        k = 0;
        while (r > 1) begin
            r = r >> 1;
            k++;
        end
        return k;
    endfunction

    // Reference model: the x in [0,N) with x*R == a*b (mod N).
    function automatic int ref_mont(input int av, input int bv, input int n, input int r);
        int target;
        target = (av * bv) % n;
        for (int x = 0; x < n; x++) begin
            if (((x * r) % n) == target) return x;
        end
        return -1;
    endfunction

    // Driver: launch one request and wait (bounded) for done.
    task automatic run_op(input int ta, input int tb_v, input int tn, input int tr,
                          output int res, output int e, output int cyc,
                          output logic busy_seen);
        @(negedge clk);
        a        = W'(ta);
        b        = W'(tb_v);
        modulant = W'(tn);
        r_in     = (W+1)'(tr);
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_seen = busy;
        cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            total++;
            if (!done && err !== 1'b0) begin
                bad++;
                $display("FAIL err_without_done: cycle=%0d err=%b expected 0", c, err);
            end
            if (done === 1'b1) begin
                cyc = c;
                break;
            end
        end
        total++;
        if (cyc == 0) begin
            bad++;
            $display("FAIL done_timeout: no done within 40 cycles (N=%0d r=%0d)", tn, tr);
        end
        res = int'(result);
        e   = int'(err);
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse_width: done=%b one cycle later, expected 0", done);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        modulant = '0;
        r_in     = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL reset_state: result=%0d busy=%b done=%b err=%b state=%0d expected all 0",
                     result, busy, done, err, state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_op(input string name, input int ta, input int tb_v, input int tn,
                            input int tr, input int exp_res, input int exp_err, input int exp_cyc);
        int res, e, cyc;
        logic bs;
        run_op(ta, tb_v, tn, tr, res, e, cyc, bs);
        total++;
        if (res != exp_res) begin
            bad++;
            $display("FAIL %s_result: got %0d expected %0d", name, res, exp_res);
        end
        total++;
        if (e != exp_err) begin
            bad++;
            $display("FAIL %s_err: got %0d expected %0d", name, e, exp_err);
        end
        total++;
        if (cyc != exp_cyc) begin
            bad++;
            $display("FAIL %s_latency: done at cycle %0d expected %0d", name, cyc, exp_cyc);
        end
        total++;
        if (bs !== 1'b1) begin
            bad++;
            $display("FAIL %s_busy: busy=%b after acceptance expected 1", name, bs);
        end
    endtask

    task automatic test_basic();
        check_op("basic", 5, 7, 13, 16, 3, 0, 6);
    endtask

    task automatic test_final_sub();
        check_op("final_sub", 14, 14, 15, 16, 1, 0, 6);
    endtask

    task automatic test_full_width();
        check_op("full_width", 1, 1, 255, 256, 1, 0, 10);
    endtask

    task automatic test_mid_reset();
        logic saw_done;
        @(negedge clk);
        a = 8'd200; b = 8'd100; modulant = 8'd255; r_in = 9'd256; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (result !== '0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || state_dbg !== IDLE) begin
            bad++;
            $display("FAIL mid_reset_outputs: result=%0d busy=%b done=%b err=%b state=%0d expected all 0",
                     result, busy, done, err, state_dbg);
        end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_no_done: saw done=%b after abort expected 0", saw_done);
        end
    endtask

    task automatic test_illegal_busy();
        int cyc;
        logic saw_done;
        @(negedge clk);
        a = 8'd3; b = 8'd4; modulant = 8'd12; r_in = 9'd16; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        // Legal request presented while busy must be ignored.
        @(negedge clk);
        a = 8'd5; b = 8'd7; modulant = 8'd13; r_in = 9'd16; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = (done === 1'b1) ? 1 : 0;
        for (int c = 2; c <= 10 && cyc == 0; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) cyc = c;
        end
        total++;
        if (cyc != 2) begin
            bad++;
            $display("FAIL illegal_latency: done at cycle %0d expected 2", cyc);
        end
        total++;
        if (err !== 1'b1 || result !== '0) begin
            bad++;
            $display("FAIL illegal_outputs: err=%b result=%0d expected err=1 result=0", err, result);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) saw_done = 1'b1;
        end
        total++;
        if (saw_done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_start_ignored: done=%b busy=%b after ignored start expected 0 0",
                     saw_done, busy);
        end
    endtask

    task automatic test_illegal_mix();
        check_op("zero_mod", 0, 0, 0, 16, 0, 1, 2);
        check_op("r_le_n", 1, 2, 17, 16, 0, 1, 2);
        check_op("r_not_pow2", 1, 2, 5, 12, 0, 1, 2);
        check_op("r_one", 0, 0, 1, 1, 0, 1, 2);
    endtask

    task automatic test_random();
        int n, r, av, bv, exp_res, exp_cyc, res, e, cyc;
        logic bs;
        for (int i = 0; i < 1000; i++) begin
            n  = $urandom_range(1, 255) | 1;
            r  = ref_r(n);
            av = $urandom_range(0, n - 1);
            bv = $urandom_range(0, n - 1);
            exp_res = ref_mont(av, bv, n, r);
            exp_cyc = ref_k(r) + 2;
            run_op(av, bv, n, r, res, e, cyc, bs);
            total++;
            if (res != exp_res || e != 0) begin
                bad++;
                $display("FAIL random_result: a=%0d b=%0d N=%0d R=%0d got %0d err=%0d expected %0d err=0",
                         av, bv, n, r, res, e, exp_res);
            end
            total++;
            if (cyc != exp_cyc) begin
                bad++;
                $display("FAIL random_latency: N=%0d R=%0d done at %0d expected %0d", n, r, cyc, exp_cyc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_final_sub();
        test_full_width();
        test_mid_reset();
        test_illegal_busy();
        test_illegal_mix();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
